// File: rtl/cache_pkg.sv
// Shared parameters, FSM encoding and helpers for the
// cache line refill controller.
package cache_pkg;

  localparam int TAG_W    = 24;
  localparam int SET_W    = 3;
  localparam int OFFSET_W = 5;
  localparam int LINE_W   = 256;
  localparam int WAYS     = 8;
  localparam int BEATS    = 8;
  localparam int BEAT_W   = 32;
  localparam int NUM_SETS = 1 << SET_W;
  localparam int PTR_W    = $clog2(WAYS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BEAT = 2'd2,
    FILL = 2'd3
  } refillStateT;

  function automatic logic [WAYS-1:0] oneHot(
    input logic [PTR_W-1:0] idx
  );
    logic [WAYS-1:0] res;
    res      = '0;
    res[idx] = 1'b1;
    return res;
  endfunction

endpackage

// File: rtl/victim_rr_table.sv
// Per-set round-robin victim pointers with a
// set-indexed one-hot way select.
module victim_rr_table
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [SET_W-1:0] rdSet,
  input  logic             incEn,
  output logic [WAYS-1:0]  wayOneHot
);

  logic [PTR_W-1:0] ptrs [NUM_SETS];

  // advance only the pointer of the set being filled
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SETS; i++) begin
        ptrs[i] <= '0;
      end
    end else if (incEn) begin
      ptrs[rdSet] <= ptrs[rdSet] + 1'b1;
    end
  end

  assign wayOneHot = oneHot(ptrs[rdSet]);

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss-driven line refill: burst read, beat assembly
// and a one-cycle block write into the victim way.
module cache_refill_ctrl #(
  parameter int TAG_W = cache_pkg::TAG_W,
  parameter int WAYS  = cache_pkg::WAYS,
  parameter int BEATS = cache_pkg::BEATS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        miss_req,
  input  logic [31:0]                 miss_addr,
  output logic                        miss_ack,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic [31:0]                 mem_addr,
  input  logic                        mem_rdata_valid,
  input  logic [31:0]                 mem_rdata,
  output logic                        fill_valid,
  output logic [cache_pkg::SET_W-1:0] fill_set,
  output logic [WAYS-1:0]             fill_way,
  output logic [TAG_W-1:0]            fill_tag,
  output logic [cache_pkg::LINE_W-1:0] fill_data,
  output logic                        fill_viv,
  output logic                        busy
);

  localparam int SW = cache_pkg::SET_W;
  localparam int OW = cache_pkg::OFFSET_W;
  localparam int BW = cache_pkg::BEAT_W;
  localparam int LW = cache_pkg::LINE_W;
  localparam int KW = $clog2(BEATS);
  localparam logic [KW-1:0] LAST = KW'(BEATS - 1);

  cache_pkg::refillStateT state;
  cache_pkg::refillStateT stateNext;

  logic [TAG_W-1:0] capTag;
  logic [SW-1:0]    capSet;
  logic [KW-1:0]    beatCnt;
  logic [LW-BW-1:0] lineBuf;
  logic [LW-1:0]    lineOut;
  logic [cache_pkg::WAYS-1:0] victimWay;

  logic acceptMiss;
  logic reqDone;
  logic beatTake;
  logic fillNow;
  logic unusedBits;

  assign unusedBits = ^miss_addr[OW-1:0];

  // next state and handshake strobes; reset forces all low
  always_comb begin
    stateNext  = state;
    acceptMiss = 1'b0;
    reqDone    = 1'b0;
    beatTake   = 1'b0;
    fillNow    = 1'b0;
    unique case (state)
      cache_pkg::IDLE: begin
        if (miss_req) begin
          acceptMiss = 1'b1;
          stateNext  = cache_pkg::REQ;
        end
      end
      cache_pkg::REQ: begin
        if (mem_req_ready) begin
          reqDone   = 1'b1;
          stateNext = cache_pkg::BEAT;
        end
      end
      cache_pkg::BEAT: begin
        if (mem_rdata_valid) begin
          beatTake = 1'b1;
          if (beatCnt == LAST) begin
            stateNext = cache_pkg::FILL;
          end
        end
      end
      cache_pkg::FILL: begin
        fillNow   = 1'b1;
        stateNext = cache_pkg::IDLE;
      end
      default: stateNext = cache_pkg::IDLE;
    endcase
    if (reset) begin
      stateNext  = cache_pkg::IDLE;
      acceptMiss = 1'b0;
      reqDone    = 1'b0;
      beatTake   = 1'b0;
      fillNow    = 1'b0;
    end
  end

  // state, captured miss address, beat counter and line
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= cache_pkg::IDLE;
      capTag  <= '0;
      capSet  <= '0;
      beatCnt <= '0;
      lineBuf <= '0;
      lineOut <= '0;
    end else begin
      state <= stateNext;
      if (acceptMiss) begin
        capTag <= miss_addr[31 -: TAG_W];
        capSet <= miss_addr[OW +: SW];
      end
      if (reqDone) begin
        beatCnt <= '0;
      end
      if (beatTake) begin
        beatCnt <= beatCnt + 1'b1;
        if (beatCnt == LAST) begin
          lineOut <= {mem_rdata, lineBuf};
        end else begin
          lineBuf[beatCnt*BW +: BW] <= mem_rdata;
        end
      end
    end
  end

  victim_rr_table uVictim (
    .clk       (clk),
    .reset     (reset),
    .rdSet     (capSet),
    .incEn     (fillNow),
    .wayOneHot (victimWay)
  );

  assign miss_ack      = acceptMiss;
  assign mem_req_valid = (state == cache_pkg::REQ) && !reset;
  assign busy          = (state != cache_pkg::IDLE) && !reset;
  assign mem_addr      = 32'({capTag, capSet, {OW{1'b0}}});
  assign fill_valid    = fillNow;
  assign fill_viv      = fillNow;
  assign fill_way      = fillNow ? WAYS'(victimWay) : '0;
  assign fill_set      = capSet;
  assign fill_tag      = capTag;
  assign fill_data     = lineOut;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: directed
// vector table, reset mid-burst, randomized refills.
module tb_cache_refill_ctrl;

  logic         clk;
  logic         reset;
  logic         miss_req;
  logic [31:0]  miss_addr;
  logic         miss_ack;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [31:0]  mem_addr;
  logic         mem_rdata_valid;
  logic [31:0]  mem_rdata;
  logic         fill_valid;
  logic [2:0]   fill_set;
  logic [7:0]   fill_way;
  logic [23:0]  fill_tag;
  logic [255:0] fill_data;
  logic         fill_viv;
  logic         busy;

  cache_refill_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .miss_req        (miss_req),
    .miss_addr       (miss_addr),
    .miss_ack        (miss_ack),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_addr        (mem_addr),
    .mem_rdata_valid (mem_rdata_valid),
    .mem_rdata       (mem_rdata),
    .fill_valid      (fill_valid),
    .fill_set        (fill_set),
    .fill_way        (fill_way),
    .fill_tag        (fill_tag),
    .fill_data       (fill_data),
    .fill_viv        (fill_viv),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          d;
    int          g;
    bit          hold;
    logic [31:0] expMem;
    logic [2:0]  expSet;
    logic [23:0] expTag;
    logic [7:0]  expWay;
    int          expFill;
  } vecT;

  vecT          vec [10];
  int           gapV [8];
  logic [31:0]  dataV [8];
  int           rr [8];
  logic [255:0] lastFill;
  int           passN;
  int           failN;
  int           totalN;

  task automatic chk(input string nm,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    totalN++;
    if (act !== exp) begin
      failN++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end else begin
      passN++;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] buildLine();
    logic [255:0] l;
    l = '0;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = dataV[i];
    return l;
  endfunction

  // one complete refill, driven open-loop from cycle 0 (ack)
  task automatic doRefill(input logic [31:0]  addr,
                          input int           d,
                          input bit           hold,
                          input bit           stray,
                          input logic [31:0]  expMem,
                          input logic [2:0]   expSet,
                          input logic [23:0]  expTag,
                          input logic [7:0]   expWay,
                          input int           expFill,
                          input logic [255:0] expLine);
    int bc [8];
    int t;
    int b;
    t = 2 + d;
    for (int i = 0; i < 8; i++) begin
      t += gapV[i];
      bc[i] = t;
      t++;
    end
    b = 0;
    for (int cyc = 0; cyc <= expFill; cyc++) begin
      miss_req      = (cyc == 0) || hold;
      miss_addr     = addr;
      mem_req_ready = (cyc == 1 + d);
      if (b < 8 && cyc == bc[b]) begin
        mem_rdata_valid = 1'b1;
        mem_rdata       = dataV[b];
        b++;
      end else begin
        mem_rdata_valid = stray && (cyc < 2 + d);
        mem_rdata       = $urandom;
      end
      #4;
      chk("miss_ack", miss_ack, cyc == 0);
      chk("busy", busy, cyc > 0);
      chk("mem_req_valid", mem_req_valid,
          cyc >= 1 && cyc <= 1 + d);
      if (cyc >= 1 && cyc <= 1 + d)
        chk("mem_addr", mem_addr, expMem);
      chk("fill_valid", fill_valid, cyc == expFill);
      chk("fill_viv", fill_viv, cyc == expFill);
      chk("fill_way", fill_way,
          (cyc == expFill) ? expWay : 8'h00);
      if (cyc == expFill) begin
        chk("fill_set", fill_set, expSet);
        chk("fill_tag", fill_tag, expTag);
        chk("fill_data", fill_data, expLine);
        lastFill = fill_data;
      end
      @(posedge clk);
      #1;
    end
    miss_req        = 1'b0;
    mem_req_ready   = 1'b0;
    mem_rdata_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [31:0] addr;
    logic [2:0]  set;
    int          d;
    int          gs;
    bit          hold;
    logic [7:0]  ew;

    passN = 0;
    failN = 0;
    totalN = 0;
    reset           = 1'b1;
    miss_req        = 1'b0;
    miss_addr       = '0;
    mem_req_ready   = 1'b0;
    mem_rdata_valid = 1'b0;
    mem_rdata       = '0;

    vec[0] = '{32'hABCDE160, 0, 0, 1'b0, 32'hABCDE160,
               3'd3, 24'hABCDE1, 8'h01, 10};
    vec[1] = '{32'h12345678, 0, 0, 1'b0, 32'h12345660,
               3'd3, 24'h123456, 8'h02, 10};
    vec[2] = '{32'h00000080, 0, 0, 1'b0, 32'h00000080,
               3'd4, 24'h000000, 8'h01, 10};
    vec[3] = '{32'h00000060, 0, 0, 1'b0, 32'h00000060,
               3'd3, 24'h000000, 8'h04, 10};
    vec[4] = '{32'hFFFFFF7F, 0, 0, 1'b0, 32'hFFFFFF60,
               3'd3, 24'hFFFFFF, 8'h08, 10};
    vec[5] = '{32'h13579B6C, 0, 0, 1'b0, 32'h13579B60,
               3'd3, 24'h13579B, 8'h10, 10};
    vec[6] = '{32'h2468AC74, 5, 1, 1'b0, 32'h2468AC60,
               3'd3, 24'h2468AC, 8'h20, 22};
    vec[7] = '{32'hDEADBE7F, 0, 0, 1'b0, 32'hDEADBE60,
               3'd3, 24'hDEADBE, 8'h40, 10};
    vec[8] = '{32'hCAFEF060, 0, 0, 1'b1, 32'hCAFEF060,
               3'd3, 24'hCAFEF0, 8'h80, 10};
    vec[9] = '{32'h0BADF07C, 0, 0, 1'b0, 32'h0BADF060,
               3'd3, 24'h0BADF0, 8'h01, 10};

    cycle();
    #4;
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_req_valid", mem_req_valid, 1'b0);
    chk("rst_fill_valid", fill_valid, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #4;
    chk("rst_miss_ack", miss_ack, 1'b0);
    chk("rst_fill_way", fill_way, 8'h00);
    chk("rst_fill_viv", fill_viv, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_fill_data", fill_data, 256'h0);
    chk("rst_busy2", busy, 1'b0);
    @(posedge clk);
    #1;

    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < 8; i++) begin
        gapV[i]  = (i == 0) ? 0 : vec[v].g;
        dataV[i] = 32'(v * 256 + i);
      end
      doRefill(vec[v].addr, vec[v].d, vec[v].hold, 1'b0,
               vec[v].expMem, vec[v].expSet, vec[v].expTag,
               vec[v].expWay, vec[v].expFill, buildLine());
      if (v == 0) begin
        chk("line_word0", lastFill[31:0], 32'h0);
        chk("line_word7", lastFill[255:224], 32'h7);
      end
    end

    // reset after beat 4, then stray beats 5..7
    miss_req  = 1'b1;
    miss_addr = 32'h11111160;
    #4;
    chk("mb_ack", miss_ack, 1'b1);
    cycle();
    miss_req      = 1'b0;
    mem_req_ready = 1'b1;
    cycle();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_rdata_valid = 1'b1;
      mem_rdata       = 32'hF000_0000 + 32'(i);
      cycle();
    end
    reset     = 1'b1;
    mem_rdata = 32'hF000_0005;
    #4;
    chk("mb_rst_busy", busy, 1'b0);
    chk("mb_rst_fill_valid", fill_valid, 1'b0);
    cycle();
    reset = 1'b0;
    for (int i = 6; i < 9; i++) begin
      mem_rdata_valid = (i < 8);
      mem_rdata       = 32'hF000_0000 + 32'(i);
      #4;
      chk("mb_busy", busy, 1'b0);
      chk("mb_fill_valid", fill_valid, 1'b0);
      chk("mb_miss_ack", miss_ack, 1'b0);
      chk("mb_fill_data", fill_data, 256'h0);
      @(posedge clk);
      #1;
    end
    mem_rdata_valid = 1'b0;
    for (int s = 0; s < 8; s++) rr[s] = 0;

    for (int i = 0; i < 8; i++) begin
      gapV[i]  = 0;
      dataV[i] = 32'hC0DE_0000 + 32'(i);
    end
    doRefill(32'h55555560, 0, 1'b0, 1'b0, 32'h55555560,
             3'd3, 24'h555555, 8'h01, 10, buildLine());
    rr[3] = 1;

    // randomized refills against a per-set round-robin model
    for (int n = 0; n < 40; n++) begin
      r    = $urandom;
      set  = 3'($urandom_range(0, 7));
      addr = {r[31:8], set, r[4:0]};
      d    = $urandom_range(0, 3);
      gs   = 0;
      for (int i = 0; i < 8; i++) begin
        gapV[i]  = ($urandom_range(0, 3) == 0) ?
                   $urandom_range(1, 3) : 0;
        gs      += gapV[i];
        dataV[i] = $urandom;
      end
      hold = (n < 39) && ($urandom_range(0, 1) == 1);
      ew   = 8'h01 << rr[set];
      rr[set] = (rr[set] + 1) % 8;
      doRefill(addr, d, hold, $urandom_range(0, 1) == 1,
               {addr[31:5], 5'b0}, set, addr[31:8], ew,
               10 + d + gs, buildLine());
    end

    #4;
    chk("end_busy", busy, 1'b0);
    chk("end_fill_way", fill_way, 8'h00);

    $display("%0d/%0d checks passed", passN, totalN);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: TAG_W, 24, tag bits; WAYS, 8, ways per set; BEATS, 8, 32-bit beats per 256-bit line.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 miss_req  input  1  a cache miss is pending on miss_addr.
REQ-005 miss_addr  input  32  miss address: tag [31:8], set [7:5], byte offset [4:0].
REQ-006 miss_ack  output  1  one-cycle pulse; the miss is accepted.
REQ-007 mem_req_valid  output  1  burst read request to memory.
REQ-008 mem_req_ready  input  1  memory accepts the request.
REQ-009 mem_addr  output  32  line-aligned address: {tag, set, 5'b0}.
REQ-010 mem_rdata_valid  input  1  memory data beat valid.
REQ-011 mem_rdata  input  32  memory data beat.
REQ-012 fill_valid  output  1  one-cycle block-write strobe to the cache set.
REQ-013 fill_set  output  3  set index being filled.
REQ-014 fill_way  output  8  one-hot victim way select (decOut1b format).
REQ-015 fill_tag  output  24  tag for the halt/main tag stores (halt tag = [3:0], main tag = [23:4]).
REQ-016 fill_data  output  256  assembled line.
REQ-017 fill_viv  output  1  valid bit to write; SHALL be 1 while fill_valid=1, else 0.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 FSM states SHALL be IDLE, REQ, BEAT and FILL.
REQ-020 IDLE: when miss_req=1, the block SHALL pulse miss_ack, capture miss_addr[31:5] and go to REQ on the next cycle.
REQ-021 REQ: mem_req_valid=1 and mem_addr stable; on mem_req_ready=1, go to BEAT and clear the beat counter.
REQ-022 BEAT: each cycle with mem_rdata_valid=1 SHALL write mem_rdata into line bits [32k+31:32k], k = beat counter (0..7), then increment k.
REQ-023 BEAT: the beat with k=7 SHALL move the FSM to FILL.
REQ-024 BEAT: cycles with mem_rdata_valid=0 SHALL stall with no state change; gaps between beats are unbounded.
REQ-025 mem_rdata_valid outside BEAT SHALL be ignored.
REQ-026 FILL: fill_valid=1 for exactly one cycle, with fill_set/fill_tag from the captured address and fill_way = onehot(victim_ptr[set]).
REQ-027 FILL: on the same edge, victim_ptr[set] SHALL increment modulo 8 (7 wraps to 0); the FSM returns to IDLE.
REQ-028 victim_ptr SHALL be eight 3-bit round-robin pointers, one per set, independent of each other.
REQ-029 miss_req while busy=1 SHALL not be acknowledged; it is accepted in IDLE the cycle after FILL at the earliest.
REQ-030 Minimum latency SHALL be: miss_ack at cycle 0, mem_req_valid at cycle 1, beats at cycles 2..9 with no stalls, fill_valid at cycle 10.
REQ-031 Outside FILL, fill_data SHALL hold the last assembled line and fill_way SHALL be 8'b0.
REQ-032 miss_ack and fill_valid SHALL never be high in the same cycle.

Reset
REQ-033 On reset=1 at a clock edge, from any state including mid-burst, the FSM SHALL go to IDLE.
REQ-034 Reset SHALL clear the beat counter, all victim pointers, the captured address and fill_data to 0.
REQ-035 Reset SHALL drive miss_ack, mem_req_valid, fill_valid, fill_viv and busy to 0, fill_way to 8'b0 and mem_addr to 0.
REQ-036 The block SHALL not assume the memory aborts a burst on reset; beats arriving after reset SHALL be ignored per REQ-025.

Structure
REQ-037 A shared package cache_pkg SHALL hold TAG_W, SET_W=3, OFFSET_W=5, LINE_W=256, WAYS, BEATS and the FSM state encoding.
REQ-038 One sub-module, victim_rr_table (per-set pointers, set-indexed read, increment enable, one-hot output), SHALL hold the replacement state; the rest SHALL be flat.

Verification
REQ-039 Single miss: miss_addr=32'hABCDE160, ready immediate, beats 32'h0..32'h7 -> mem_addr=32'hABCDE160; fill_set=3; fill_tag=24'hABCDE1; fill_way=8'h01; fill_data[31:0]=0; fill_data[255:224]=7; fill_valid at cycle 10.
REQ-040 Round-robin: nine misses to set 3 -> fill_way sequence 01,02,04,...,80,01; a miss to set 4 in between gets 8'h01.
REQ-041 Stalls: mem_req_ready held low 5 cycles and one idle cycle between every beat -> correct line assembled and fill_valid delayed by exactly the stall count.
REQ-042 Busy rejection: miss_req held high through a refill -> exactly one miss_ack per refill, and the second is acknowledged the cycle after fill_valid.
REQ-043 Reset mid-burst after beat 4 -> IDLE next cycle, no fill_valid, victim_ptr=0; stray beats ignored; the next miss fills way 8'h01.
